ps2_serial_tx: RTL and testbench

- Keyboard-side serial terminal transmitter for the Altair machine; drives the machine's serial `rx` line.
- Takes PS/2 key events from hps_io (`ps2_key`, clocked in the CLK_50M domain via existing CDC) and translates scan-code set 2 to ASCII.
- Queues characters in a small FIFO and sends them as 8N1 UART frames.
- Acts as the transmitting end for the machine's ACIA receiver.

---
 rtl/ps2_serial_tx.sv | 268 ++++++++++++++++++++++++++
 tb/tb_ps2_serial_tx.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_serial_tx.sv
// PS/2 set-2 key events -> ASCII -> character FIFO -> 8N1 UART transmitter.
// Feeds the machine's serial rx line from the front-panel keyboard.
module ps2_serial_tx #(
  parameter int CLK_HZ      = 50000000,
  parameter int BAUD        = 115200,
  parameter int FIFO_DEPTH  = 16,
  parameter int FORCE_UPPER = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [10:0]                   ps2_key,
  input  logic                          hold,
  output logic                          tx_o,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow
);

  localparam int DIV = CLK_HZ / BAUD;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int LW  = PW + 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  // Stage 1: event detect
  logic       prev_tog;
  logic       ev_valid;
  logic       ev_press;
  logic       ev_ext;
  logic [7:0] ev_code;

  always_ff @(posedge clk) begin
    if (!reset) begin
      prev_tog <= ps2_key[10];
      ev_valid <= 1'b0;
      ev_press <= 1'b0;
      ev_ext   <= 1'b0;
      ev_code  <= '0;
    end else begin
      prev_tog <= ps2_key[10];
      ev_valid <= ps2_key[10] ^ prev_tog;
      ev_press <= ps2_key[9];
      ev_ext   <= ps2_key[8];
      ev_code  <= ps2_key[7:0];
    end
  end

  // Stage 2: modifiers and translation
  logic       shift;
  logic       ctrl;
  logic       char_valid;
  logic [7:0] char_data;
  logic       xlat_valid;
  logic [7:0] xlat_char;
  logic       is_letter;
  logic [7:0] lo;
  logic [7:0] hi;
  logic [7:0] up;

  always_comb begin
    xlat_valid = 1'b1;
    is_letter  = 1'b0;
    lo         = '0;
    hi         = '0;
    case (ev_code)
      8'h1C: begin is_letter = 1'b1; lo = "a"; end
      8'h32: begin is_letter = 1'b1; lo = "b"; end
      8'h21: begin is_letter = 1'b1; lo = "c"; end
      8'h23: begin is_letter = 1'b1; lo = "d"; end
      8'h24: begin is_letter = 1'b1; lo = "e"; end
      8'h2B: begin is_letter = 1'b1; lo = "f"; end
      8'h34: begin is_letter = 1'b1; lo = "g"; end
      8'h33: begin is_letter = 1'b1; lo = "h"; end
      8'h43: begin is_letter = 1'b1; lo = "i"; end
      8'h3B: begin is_letter = 1'b1; lo = "j"; end
      8'h42: begin is_letter = 1'b1; lo = "k"; end
      8'h4B: begin is_letter = 1'b1; lo = "l"; end
      8'h3A: begin is_letter = 1'b1; lo = "m"; end
      8'h31: begin is_letter = 1'b1; lo = "n"; end
      8'h44: begin is_letter = 1'b1; lo = "o"; end
      8'h4D: begin is_letter = 1'b1; lo = "p"; end
      8'h15: begin is_letter = 1'b1; lo = "q"; end
      8'h2D: begin is_letter = 1'b1; lo = "r"; end
      8'h1B: begin is_letter = 1'b1; lo = "s"; end
      8'h2C: begin is_letter = 1'b1; lo = "t"; end
      8'h3C: begin is_letter = 1'b1; lo = "u"; end
      8'h2A: begin is_letter = 1'b1; lo = "v"; end
      8'h1D: begin is_letter = 1'b1; lo = "w"; end
      8'h22: begin is_letter = 1'b1; lo = "x"; end
      8'h35: begin is_letter = 1'b1; lo = "y"; end
      8'h1A: begin is_letter = 1'b1; lo = "z"; end
      8'h16: begin lo = "1"; hi = "!"; end
      8'h1E: begin lo = "2"; hi = "@"; end
      8'h26: begin lo = "3"; hi = "#"; end
      8'h25: begin lo = "4"; hi = "$"; end
      8'h2E: begin lo = "5"; hi = "%"; end
      8'h36: begin lo = "6"; hi = "^"; end
      8'h3D: begin lo = "7"; hi = "&"; end
      8'h3E: begin lo = "8"; hi = "*"; end
      8'h46: begin lo = "9"; hi = "("; end
      8'h45: begin lo = "0"; hi = ")"; end
      8'h4E: begin lo = "-"; hi = "_"; end
      8'h55: begin lo = "="; hi = "+"; end
      8'h54: begin lo = "["; hi = "{"; end
      8'h5B: begin lo = "]"; hi = "}"; end
      8'h5D: begin lo = 8'h5C; hi = "|"; end
      8'h4C: begin lo = ";"; hi = ":"; end
      8'h52: begin lo = 8'h27; hi = 8'h22; end
      8'h41: begin lo = ","; hi = "<"; end
      8'h49: begin lo = "."; hi = ">"; end
      8'h4A: begin lo = "/"; hi = "?"; end
      8'h0E: begin lo = 8'h60; hi = "~"; end
      8'h29: begin lo = 8'h20; hi = 8'h20; end
      8'h5A: begin lo = 8'h0D; hi = 8'h0D; end
      8'h66: begin lo = 8'h08; hi = 8'h08; end
      8'h76: begin lo = 8'h1B; hi = 8'h1B; end
      8'h0D: begin lo = 8'h09; hi = 8'h09; end
      default: xlat_valid = 1'b0;
    endcase
    up = lo & 8'hDF;
    if (is_letter) begin
      if (ctrl)
        xlat_char = up & 8'h1F;
      else if ((FORCE_UPPER != 0) || shift)
        xlat_char = up;
      else
        xlat_char = lo;
    end else begin
      xlat_char = shift ? hi : lo;
    end
  end

  // Modifier state tracks both plain and extended variants (right ctrl is E0 14)
  always_ff @(posedge clk) begin
    if (!reset) begin
      shift      <= 1'b0;
      ctrl       <= 1'b0;
      char_valid <= 1'b0;
      char_data  <= '0;
    end else begin
      if (ev_valid && (ev_code == 8'h12 || ev_code == 8'h59))
        shift <= ev_press;
      if (ev_valid && ev_code == 8'h14)
        ctrl <= ev_press;
      char_valid <= ev_valid && ev_press && !ev_ext && xlat_valid;
      char_data  <= xlat_char;
    end
  end

  // Character FIFO
  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [LW-1:0] count;
  logic          pop;
  logic          fifo_empty;
  logic          fifo_full;
  logic          push_ok;

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == LW'(FIFO_DEPTH));
  // A pop in the same cycle frees the head slot, so a full FIFO still accepts
  assign push_ok    = char_valid && (!fifo_full || pop);

  always_ff @(posedge clk) begin
    if (reset && push_ok)
      mem[wr_ptr] <= char_data;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      if (char_valid && !push_ok)
        overflow <= 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign fifo_level = count;

  // Transmit FSM
  state_t        state;
  state_t        next_state;
  logic [CW-1:0] baud_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          bit_end;

  assign bit_end = (baud_cnt == CW'(DIV - 1));

  always_comb begin
    next_state = state;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty && !hold) begin
          pop        = 1'b1;
          next_state = START;
        end
      end
      START: begin
        if (bit_end)
          next_state = DATA;
      end
      DATA: begin
        if (bit_end && bit_idx == 3'd7)
          next_state = STOP;
      end
      STOP: begin
        // Chain straight into the next start bit so queued frames have no idle gap
        if (bit_end) begin
          if (!fifo_empty && !hold) begin
            pop        = 1'b1;
            next_state = START;
          end else begin
            next_state = IDLE;
          end
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
    end else begin
      state <= next_state;
      if (pop)
        shreg <= mem[rd_ptr];
      if (state == IDLE || bit_end)
        baud_cnt <= '0;
      else
        baud_cnt <= baud_cnt + 1'b1;
      if (state != DATA)
        bit_idx <= '0;
      else if (bit_end)
        bit_idx <= bit_idx + 1'b1;
    end
  end

  always_comb begin
    case (state)
      START:   tx_o = 1'b0;
      DATA:    tx_o = shreg[bit_idx];
      default: tx_o = 1'b1;
    endcase
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_ps2_serial_tx.sv
// Directed bench for ps2_serial_tx: translation, latency, FIFO overflow,
// back-to-back frames, mid-frame reset and full-FIFO push/pop.
module tb_ps2_serial_tx;

  localparam int CLK_HZ = 50000000;
  localparam int BAUD   = 4500000;
  localparam int DIV    = CLK_HZ / BAUD;  // 11: short bits keep the run brief
  localparam int DEPTH  = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [10:0] ps2_key = '0;
  logic        hold = 1'b0;
  logic        tx_o;
  logic        busy;
  logic [4:0]  fifo_level;
  logic        overflow;

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  logic tog = 1'b0;

  logic [7:0] letters [20] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34,
                               8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31,
                               8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C};

  ps2_serial_tx #(
    .CLK_HZ(CLK_HZ),
    .BAUD(BAUD),
    .FIFO_DEPTH(DEPTH),
    .FORCE_UPPER(1)
  ) dut (
    .clk(clk),
    .reset(reset),
    .ps2_key(ps2_key),
    .hold(hold),
    .tx_o(tx_o),
    .busy(busy),
    .fifo_level(fifo_level),
    .overflow(overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_key(input logic press, input logic ext, input logic [7:0] code);
    @(negedge clk);
    tog = ~tog;
    ps2_key = {tog, press, ext, code};
  endtask

  task automatic watch_line(input int n, output logic low_seen);
    low_seen = 1'b0;
    repeat (n) begin
      @(negedge clk);
      if (tx_o !== 1'b1) low_seen = 1'b1;
    end
  endtask

  // Waits (bounded) for a start bit, then samples each bit at its centre.
  task automatic rx_frame(output logic [7:0] data, output logic ok, output int start_cyc);
    ok = 1'b1;
    data = '0;
    start_cyc = -1;
    for (int i = 0; i < 2000 && tx_o !== 1'b0; i++) @(negedge clk);
    if (tx_o !== 1'b0) begin
      ok = 1'b0;
      return;
    end
    start_cyc = cyc;
    repeat (DIV / 2) @(negedge clk);
    if (tx_o !== 1'b0) ok = 1'b0;
    for (int k = 0; k < 8; k++) begin
      repeat (DIV) @(negedge clk);
      data[k] = tx_o;
    end
    repeat (DIV) @(negedge clk);
    if (tx_o !== 1'b1) ok = 1'b0;
  endtask

  task automatic test_reset();
    logic low;
    reset = 1'b0;
    idle(3);
    total++; if (tx_o !== 1'b1) begin bad++; $display("FAIL reset_tx: got %b want 1", tx_o); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if (fifo_level !== 5'd0) begin bad++; $display("FAIL reset_level: got %0d want 0", fifo_level); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_ovf: got %b want 0", overflow); end
    reset = 1'b1;
    watch_line(20, low);
    total++; if (low !== 1'b0) begin bad++; $display("FAIL reset_quiet: got low=%b want 0", low); end
  endtask

  task automatic test_letter();
    logic [7:0] d;
    logic ok, low;
    int sc;
    send_key(1'b1, 1'b0, 8'h1C);
    idle(3);
    total++; if (tx_o !== 1'b1) begin bad++; $display("FAIL latency_early: got %b want 1", tx_o); end
    idle(1);
    total++; if (tx_o !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL latency_start: got tx=%b busy=%b want tx=0 busy=1", tx_o, busy); end
    rx_frame(d, ok, sc);
    total++; if (!ok || d !== 8'h41) begin bad++; $display("FAIL frame_A: got %h ok=%b want 41", d, ok); end
    send_key(1'b0, 1'b0, 8'h1C);
    watch_line(40, low);
    total++; if (low !== 1'b0 || fifo_level !== 5'd0) begin bad++; $display("FAIL release_quiet: got low=%b level=%0d want 0 0", low, fifo_level); end
  endtask

  task automatic test_shift();
    logic [7:0] d;
    logic ok;
    int sc;
    fork
      begin
        send_key(1'b1, 1'b0, 8'h12); idle(2);
        send_key(1'b1, 1'b0, 8'h16); idle(2);
        send_key(1'b0, 1'b0, 8'h16); idle(2);
        send_key(1'b0, 1'b0, 8'h12);
      end
      rx_frame(d, ok, sc);
    join
    total++; if (!ok || d !== 8'h21) begin bad++; $display("FAIL shift_bang: got %h ok=%b want 21", d, ok); end
    fork
      begin send_key(1'b1, 1'b0, 8'h16); idle(2); send_key(1'b0, 1'b0, 8'h16); end
      rx_frame(d, ok, sc);
    join
    total++; if (!ok || d !== 8'h31) begin bad++; $display("FAIL digit_1: got %h ok=%b want 31", d, ok); end
    fork
      begin send_key(1'b1, 1'b0, 8'h59); idle(2); send_key(1'b1, 1'b0, 8'h4E); idle(2); send_key(1'b0, 1'b0, 8'h59); end
      rx_frame(d, ok, sc);
    join
    total++; if (!ok || d !== 8'h5F) begin bad++; $display("FAIL rshift_under: got %h ok=%b want 5f", d, ok); end
  endtask

  task automatic test_ctrl_and_ignore();
    logic [7:0] d;
    logic ok, low;
    int sc;
    fork
      begin
        send_key(1'b1, 1'b0, 8'h14); idle(2);
        send_key(1'b1, 1'b0, 8'h21); idle(2);
        send_key(1'b0, 1'b0, 8'h21); idle(2);
        send_key(1'b0, 1'b0, 8'h14);
      end
      rx_frame(d, ok, sc);
    join
    total++; if (!ok || d !== 8'h03) begin bad++; $display("FAIL ctrl_c: got %h ok=%b want 03", d, ok); end
    send_key(1'b1, 1'b1, 8'h75); idle(2);
    send_key(1'b0, 1'b1, 8'h75); idle(2);
    send_key(1'b1, 1'b0, 8'h07);
    watch_line(40, low);
    total++; if (low !== 1'b0 || fifo_level !== 5'd0) begin bad++; $display("FAIL ignored_quiet: got low=%b level=%0d want 0 0", low, fifo_level); end
    fork
      send_key(1'b1, 1'b0, 8'h5A);
      rx_frame(d, ok, sc);
    join
    total++; if (!ok || d !== 8'h0D) begin bad++; $display("FAIL enter_cr: got %h ok=%b want 0d", d, ok); end
  endtask

  task automatic test_overflow_back_to_back();
    logic [7:0] d;
    logic ok, low, any_low;
    int sc, prev_sc;
    hold = 1'b1;
    any_low = 1'b0;
    for (int i = 0; i < 20; i++) begin
      send_key(1'b1, 1'b0, letters[i]);
      watch_line(2, low);
      any_low |= low;
    end
    watch_line(5, low);
    any_low |= low;
    total++; if (fifo_level !== 5'd16) begin bad++; $display("FAIL ovf_level: got %0d want 16", fifo_level); end
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag: got %b want 1", overflow); end
    total++; if (any_low !== 1'b0) begin bad++; $display("FAIL hold_quiet: got low=%b want 0", any_low); end
    @(negedge clk);
    hold = 1'b0;
    prev_sc = 0;
    for (int i = 0; i < 16; i++) begin
      rx_frame(d, ok, sc);
      total++; if (!ok || d !== 8'(8'h41 + i)) begin bad++; $display("FAIL b2b_data[%0d]: got %h ok=%b want %h", i, d, ok, 8'(8'h41 + i)); end
      if (i > 0) begin
        total++; if (sc - prev_sc !== 10 * DIV) begin bad++; $display("FAIL b2b_gap[%0d]: got %0d want %0d", i, sc - prev_sc, 10 * DIV); end
      end
      prev_sc = sc;
    end
    idle(5);
    total++; if (fifo_level !== 5'd0 || overflow !== 1'b1) begin bad++; $display("FAIL drain_end: got level=%0d ovf=%b want 0 1", fifo_level, overflow); end
  endtask

  task automatic test_hold_mid_frame();
    logic [7:0] d;
    logic ok, low;
    int sc;
    fork
      begin send_key(1'b1, 1'b0, 8'h2C); idle(8); hold = 1'b1; end
      rx_frame(d, ok, sc);
    join
    total++; if (!ok || d !== 8'h54) begin bad++; $display("FAIL hold_mid: got %h ok=%b want 54", d, ok); end
    send_key(1'b1, 1'b0, 8'h29);
    watch_line(30, low);
    total++; if (low !== 1'b0 || fifo_level !== 5'd1) begin bad++; $display("FAIL hold_blocks: got low=%b level=%0d want 0 1", low, fifo_level); end
    fork
      begin @(negedge clk); hold = 1'b0; end
      rx_frame(d, ok, sc);
    join
    total++; if (!ok || d !== 8'h20) begin bad++; $display("FAIL space: got %h ok=%b want 20", d, ok); end
  endtask

  task automatic test_reset_mid_frame();
    logic low;
    int n;
    send_key(1'b1, 1'b0, 8'h1C); idle(1);
    send_key(1'b1, 1'b0, 8'h32);
    n = 0;
    while (tx_o !== 1'b0 && n < 200) begin @(negedge clk); n++; end
    total++; if (tx_o !== 1'b0) begin bad++; $display("FAIL rmf_start: got %b want 0", tx_o); end
    repeat (4 * DIV + DIV / 2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    total++; if (tx_o !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL rmf_line: got tx=%b busy=%b want 1 0", tx_o, busy); end
    total++; if (fifo_level !== 5'd0 || overflow !== 1'b0) begin bad++; $display("FAIL rmf_state: got level=%0d ovf=%b want 0 0", fifo_level, overflow); end
    tog = 1'b1;
    ps2_key = {1'b1, 1'b1, 1'b0, 8'h1C};
    idle(2);
    reset = 1'b1;
    watch_line(40, low);
    total++; if (low !== 1'b0 || fifo_level !== 5'd0) begin bad++; $display("FAIL rmf_no_spurious: got low=%b level=%0d want 0 0", low, fifo_level); end
  endtask

  task automatic test_push_pop_full();
    logic [7:0] d;
    logic ok;
    int sc;
    hold = 1'b1;
    for (int i = 0; i < 16; i++) begin
      send_key(1'b1, 1'b0, letters[i]);
      idle(2);
    end
    idle(4);
    total++; if (fifo_level !== 5'd16 || overflow !== 1'b0) begin bad++; $display("FAIL pp_fill: got level=%0d ovf=%b want 16 0", fifo_level, overflow); end
    send_key(1'b1, 1'b0, 8'h29);
    idle(2);
    hold = 1'b0;
    @(negedge clk);
    total++; if (fifo_level !== 5'd16 || overflow !== 1'b0) begin bad++; $display("FAIL pp_same_cycle: got level=%0d ovf=%b want 16 0", fifo_level, overflow); end
    total++; if (tx_o !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL pp_started: got tx=%b busy=%b want 0 1", tx_o, busy); end
    for (int i = 0; i < 17; i++) begin
      rx_frame(d, ok, sc);
      total++;
      if (!ok || d !== ((i == 16) ? 8'h20 : 8'(8'h41 + i))) begin
        bad++;
        $display("FAIL pp_data[%0d]: got %h ok=%b want %h", i, d, ok, (i == 16) ? 8'h20 : 8'(8'h41 + i));
      end
    end
  endtask

  initial begin
    test_reset();
    test_letter();
    test_shift();
    test_ctrl_and_ignore();
    test_overflow_back_to_back();
    test_hold_mid_frame();
    test_reset_mid_frame();
    test_push_pop_full();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
